// File: rtl/branch_exec_ctrl.sv
`default_nettype none
// ============================================================================
// branch_exec_ctrl : conditional-branch sequencer over a shared RF read port
// Revision         : 1.0
// ============================================================================
module branch_exec_ctrl #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RST_PC_OUT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction_word,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            rf_req,
  output logic [4:0]      rf_addr,
  input  logic            rf_gnt,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            illegal,
  output logic            misaligned
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ1 = 3'd1,
    S_REQ2 = 3'd2,
    S_EVAL = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [6:0]      C_OPC_BRANCH = 7'b1100011;
  localparam logic [XLEN-1:0] C_PC_INC     = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic            ill_q, ill_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic            pend1_q, pend1_d;
  logic            pend2_q, pend2_d;
  logic            rf_req_q, rf_req_d;
  logic [4:0]      rf_addr_q, rf_addr_d;
  logic            out_valid_q, out_valid_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] next_q, next_d;
  logic            illegal_q, illegal_d;
  logic            mis_q, mis_d;

  // Instruction field decode
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_imm;
  logic            w_dec_ill;

  assign w_opcode  = instruction_word[6:0];
  assign w_funct3  = instruction_word[14:12];
  assign w_rs1     = instruction_word[19:15];
  assign w_rs2     = instruction_word[24:20];
  assign w_imm     = {{(XLEN-13){instruction_word[31]}}, instruction_word[31],
                      instruction_word[7], instruction_word[30:25],
                      instruction_word[11:8], 1'b0};
  assign w_dec_ill = (w_opcode != C_OPC_BRANCH) || (w_funct3 == 3'b010) ||
                     (w_funct3 == 3'b011);

  // Operands seen by EVAL: read data arriving this cycle bypasses the register
  logic [XLEN-1:0] w_a, w_b, w_target;
  logic            w_eq, w_lt, w_ltu, w_cond, w_gnt;

  assign w_a      = pend1_q ? rf_rdata : op1_q;
  assign w_b      = pend2_q ? rf_rdata : op2_q;
  assign w_eq     = (w_a == w_b);
  assign w_lt     = ($signed(w_a) < $signed(w_b));
  assign w_ltu    = (w_a < w_b);
  assign w_target = pc_q + imm_q;
  assign w_gnt    = rf_req_q && rf_gnt;

  always_comb begin
    case (funct3_q)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = !w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    funct3_d    = funct3_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    ill_d       = ill_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    pend1_d     = pend1_q;
    pend2_d     = pend2_q;
    taken_d     = taken_q;
    target_d    = target_q;
    next_d      = next_q;
    illegal_d   = illegal_q;
    mis_d       = mis_q;

    if (pend1_q) begin
      op1_d   = rf_rdata;
      pend1_d = 1'b0;
    end
    if (pend2_q) begin
      op2_d   = rf_rdata;
      pend2_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pc_d     = pc;
          imm_d    = w_imm;
          funct3_d = w_funct3;
          rs1_d    = w_rs1;
          rs2_d    = w_rs2;
          ill_d    = w_dec_ill;
          op1_d    = '0;
          op2_d    = '0;
          // x0 is never fetched; illegal words skip the RF entirely
          if (w_dec_ill)          state_d = S_EVAL;
          else if (w_rs1 != 5'd0) state_d = S_REQ1;
          else if (w_rs2 != 5'd0) state_d = S_REQ2;
          else                    state_d = S_EVAL;
        end
      end
      S_REQ1: begin
        if (w_gnt) begin
          pend1_d = 1'b1;
          state_d = (rs2_q != 5'd0) ? S_REQ2 : S_EVAL;
        end
      end
      S_REQ2: begin
        if (w_gnt) begin
          pend2_d = 1'b1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        taken_d   = !ill_q && w_cond;
        target_d  = w_target;
        next_d    = (!ill_q && w_cond) ? w_target : pc_q + C_PC_INC;
        illegal_d = ill_q;
        mis_d     = !ill_q && w_cond && w_target[1];
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pend1_d = 1'b0;
      pend2_d = 1'b0;
    end

    // PC outputs park at the reset value whenever the block returns to idle
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      target_d = RST_PC_OUT;
      next_d   = RST_PC_OUT;
    end

    rf_req_d    = (state_d == S_REQ1) || (state_d == S_REQ2);
    out_valid_d = (state_d == S_RESP);
    if (state_d == S_REQ1)      rf_addr_d = rs1_d;
    else if (state_d == S_REQ2) rf_addr_d = rs2_d;
    else                        rf_addr_d = rf_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      imm_q       <= '0;
      funct3_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      ill_q       <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      pend1_q     <= 1'b0;
      pend2_q     <= 1'b0;
      rf_req_q    <= 1'b0;
      rf_addr_q   <= '0;
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= RST_PC_OUT;
      next_q      <= RST_PC_OUT;
      illegal_q   <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      funct3_q    <= funct3_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      ill_q       <= ill_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      pend1_q     <= pend1_d;
      pend2_q     <= pend2_d;
      rf_req_q    <= rf_req_d;
      rf_addr_q   <= rf_addr_d;
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      target_q    <= target_d;
      next_q      <= next_d;
      illegal_q   <= illegal_d;
      mis_q       <= mis_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign rf_req     = rf_req_q;
  assign rf_addr    = rf_addr_q;
  assign out_valid  = out_valid_q;
  assign taken      = taken_q;
  assign target_pc  = target_q;
  assign next_pc    = next_q;
  assign illegal    = illegal_q;
  assign misaligned = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_exec_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_exec_ctrl : scoreboard bench for branch_exec_ctrl
// Revision            : 1.0
// ============================================================================
module tb_branch_exec_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0F00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction_word = '0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        rf_req;
  logic [4:0]  rf_addr;
  logic        rf_gnt = 1'b0;
  logic [31:0] rf_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        taken;
  logic [31:0] target_pc;
  logic [31:0] next_pc;
  logic        illegal;
  logic        misaligned;

  branch_exec_ctrl #(.XLEN(32), .RST_PC_OUT(RST_PC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_word(instruction_word), .pc(pc), .flush(flush),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_gnt(rf_gnt), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .target_pc(target_pc), .next_pc(next_pc), .illegal(illegal),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] nxt;
    logic        ill;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input logic tk, input logic [31:0] tgt, input logic [31:0] nxt,
                              input logic ill, input logic mis, input int lat);
    exp_t e;
    e.tk = tk; e.tgt = tgt; e.nxt = nxt; e.ill = ill; e.mis = mis; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Register-file model: grants after gnt_cfg withheld cycles on a fresh request,
  // data returned one cycle after grant, garbage otherwise.
  logic [31:0] rf_mem [32];
  logic [4:0]  gnt_log[$];
  int          gnt_cfg = 0;
  int          gnt_left = 0;
  logic        prev_req = 1'b0;
  logic        last_gnt = 1'b0;
  logic [4:0]  last_addr = '0;

  always @(negedge clk) begin
    rf_rdata = last_gnt ? rf_mem[last_addr] : 32'hDEAD_BEEF;
    last_gnt = 1'b0;
    rf_gnt   = 1'b0;
    if (rf_req && !prev_req) gnt_left = gnt_cfg;
    if (rf_req) begin
      if (gnt_left > 0) gnt_left--;
      else begin
        rf_gnt    = 1'b1;
        last_gnt  = 1'b1;
        last_addr = rf_addr;
        gnt_log.push_back(rf_addr);
      end
    end
    prev_req = rf_req;
  end

  // Monitor: drives out_ready, checks stability and pops the scoreboard on handoff
  int          rdy_cfg = 0;
  int          rdy_cnt = 0;
  logic        prev_ov = 1'b0;
  int          first_cyc = 0;
  logic        s_tk;
  logic [31:0] s_tgt, s_nxt;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      chk("in_ready_in_resp", 32'(in_ready), 32'd0);
      if (!prev_ov) begin
        first_cyc = cyc;
        rdy_cnt   = rdy_cfg;
        s_tk      = taken;
        s_tgt     = target_pc;
        s_nxt     = next_pc;
      end else begin
        chk("stable_taken", 32'(taken), 32'(s_tk));
        chk("stable_target", target_pc, s_tgt);
        chk("stable_next", next_pc, s_nxt);
      end
      if (rdy_cnt > 0) begin
        out_ready = 1'b0;
        rdy_cnt--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("taken", 32'(taken), 32'(e.tk));
          chk("target_pc", target_pc, e.tgt);
          chk("next_pc", next_pc, e.nxt);
          chk("illegal", 32'(illegal), 32'(e.ill));
          chk("misaligned", 32'(misaligned), 32'(e.mis));
          chk("latency", 32'(first_cyc - e.acc), 32'(e.lat));
        end
      end
    end else begin
      out_ready = 1'b0;
    end
    prev_ov = out_valid;
  end

  // Called on a negedge; returns on the negedge after acceptance
  task automatic send(input logic [31:0] iw, input logic [31:0] p, input exp_t e, input bit push);
    int n;
    in_valid = 1'b1;
    instruction_word = iw;
    pc = p;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    e.acc = cyc;
    if (push) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("result_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_gnts(input int n, input logic [4:0] a0, input logic [4:0] a1);
    chk("gnt_count", 32'(gnt_log.size()), 32'(n));
    if (n > 0 && gnt_log.size() > 0) chk("gnt_addr0", 32'(gnt_log[0]), 32'(a0));
    if (n > 1 && gnt_log.size() > 1) chk("gnt_addr1", 32'(gnt_log[1]), 32'(a1));
    gnt_log.delete();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + 32'(i);
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd5;
    rf_mem[3] = 32'd1;
    rf_mem[4] = 32'hFFFF_FFFF;

    repeat (2) @(negedge clk);
    chk("rst_rf_req", 32'(rf_req), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_target", target_pc, RST_PC);
    chk("rst_next", next_pc, RST_PC);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // BEQ x1,x2,+8 taken
    send(32'h0020_8463, 32'h100, mk(1'b1, 32'h108, 32'h108, 1'b0, 1'b0, 4), 1'b1);
    wait_done();
    chk_gnts(2, 5'd1, 5'd2);

    // BLT x4,x3,-4 signed taken, then BLTU not taken
    send(32'hFE32_4EE3, 32'h200, mk(1'b1, 32'h1FC, 32'h1FC, 1'b0, 1'b0, 4), 1'b1);
    wait_done();
    chk_gnts(2, 5'd4, 5'd3);
    send(32'hFE32_6EE3, 32'h200, mk(1'b0, 32'h1FC, 32'h204, 1'b0, 1'b0, 4), 1'b1);
    wait_done();
    chk_gnts(2, 5'd4, 5'd3);

    // BEQ x0,x0,+8: no RF traffic
    send(32'h0000_0463, 32'h40, mk(1'b1, 32'h48, 32'h48, 1'b0, 1'b0, 2), 1'b1);
    wait_done();
    chk_gnts(0, 5'd0, 5'd0);

    // BNE x1,x2 with grant withheld 3 cycles and out_ready withheld 2 cycles
    gnt_cfg = 3;
    rdy_cfg = 2;
    send(32'h0020_9463, 32'h300, mk(1'b0, 32'h308, 32'h304, 1'b0, 1'b0, 7), 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("stall_rf_req", 32'(rf_req), 32'd1);
      chk("stall_rf_addr", 32'(rf_addr), 32'd1);
      @(negedge clk);
    end
    wait_done();
    chk_gnts(2, 5'd1, 5'd2);
    gnt_cfg = 0;
    rdy_cfg = 0;

    // Illegal funct3, then a taken branch to pc+2
    send(32'h0020_A463, 32'h10, mk(1'b0, 32'h18, 32'h14, 1'b1, 1'b0, 2), 1'b1);
    wait_done();
    chk_gnts(0, 5'd0, 5'd0);
    send(32'h0000_0163, 32'h40, mk(1'b1, 32'h42, 32'h42, 1'b0, 1'b1, 2), 1'b1);
    wait_done();
    chk_gnts(0, 5'd0, 5'd0);

    // Flush in the grant cycle of REQ2: nothing must come out
    send(32'h0020_8463, 32'h100, mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0), 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_rf_req", 32'(rf_req), 32'd0);
    chk("flush_target", target_pc, RST_PC);
    repeat (6) @(negedge clk);
    chk_gnts(2, 5'd1, 5'd2);

    // Reset while holding a result in RESP
    rdy_cfg = 1000;
    send(32'h0000_0463, 32'h80, mk(1'b1, 32'h88, 32'h88, 1'b0, 1'b0, 2), 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("resp_reached", 32'(out_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("amid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("amid_rst_taken", 32'(taken), 32'd0);
    chk("amid_rst_target", target_pc, RST_PC);
    chk("amid_rst_next", next_pc, RST_PC);
    chk("amid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    rdy_cfg = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    gnt_log.delete();

    // BGE x3,x4,+16 after reset
    send(32'h0041_D863, 32'h500, mk(1'b1, 32'h510, 32'h510, 1'b0, 1'b0, 4), 1'b1);
    wait_done();
    chk_gnts(2, 5'd3, 5'd4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
